// File: rtl/riscv_pkg.sv
// Shared definitions for the register file slice.
// Contents:
//   XLEN_DEFAULT      - default data width
//   REG_DEPTH_DEFAULT - default number of registers
//   rf_state_t        - clear-engine state (RF_CLEAR, RF_RUN)
//   ZERO_ADDR         - address of the hardwired-zero register
package riscv_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int REG_DEPTH_DEFAULT = 32;
    localparam int ZERO_ADDR         = 0;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the multiport register file.
// Selects one register out of the flattened storage image, forces the
// hardwired-zero register to read 0, and drives 0 while the clear engine runs.
// Optional write-through bypass is compiled in when REGFILE_BYPASS_EN is
// defined; in that build the current write port is also an input.
// Ports:
//   run      in   1            storage is valid (clear sequence finished)
//   ra       in   AW           read address
//   mem_flat in   DEPTH*XLEN   register image, entry i at [i*XLEN +: XLEN]
//   we/wa/wd in   1/AW/XLEN    write port (REGFILE_BYPASS_EN only)
//   rd       out  XLEN         read data
module regfile_read_port
    import riscv_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEFAULT,
    parameter int  DEPTH    = REG_DEPTH_DEFAULT,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  run,
    input  logic [AW-1:0]         ra,
    input  logic [DEPTH*XLEN-1:0] mem_flat,
`ifdef REGFILE_BYPASS_EN
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
`endif
    output logic [XLEN-1:0]       rd
);

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_ADDR);

    logic zero_hit;
    logic bypass_hit;

    assign zero_hit = (ZERO_REG != 0) && (ra == ZERO_A);

`ifdef REGFILE_BYPASS_EN
    // A write to register 0 under ZERO_REG never reaches here because
    // zero_hit already wins for that address.
    assign bypass_hit = we && (wa == ra);
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        rd = '0;
        if (run && !zero_hit) begin
`ifdef REGFILE_BYPASS_EN
            if (bypass_hit) begin
                rd = wd;
            end else begin
                rd = mem_flat[int'(ra)*XLEN +: XLEN];
            end
`else
            rd = bypass_hit ? '0 : mem_flat[int'(ra)*XLEN +: XLEN];
`endif
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file with NRD combinational read ports, one write
// port and an optional hardwired-zero register 0.
// After reset a clear engine writes 0 to one register per cycle; READY rises
// on the edge that clears the last entry. Writes are dropped and all reads
// return 0 until then.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through
// from the write port to any read port addressing the same register.
// Ports:
//   CLK    in   1         clock
//   RST    in   1         synchronous active-high reset, restarts the clear
//   RA     in   NRD*AW    read addresses, port i at [i*AW +: AW]
//   RD     out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//   A3     in   AW        write address
//   WD3    in   XLEN      write data
//   WE3    in   1         write enable
//   READY  out  1         clear sequence complete
module regfile_multiport
    import riscv_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEFAULT,
    parameter int  DEPTH    = REG_DEPTH_DEFAULT,
    parameter int  NRD      = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NRD*AW-1:0]   RA,
    output logic [NRD*XLEN-1:0] RD,
    input  logic [AW-1:0]       A3,
    input  logic [XLEN-1:0]     WD3,
    input  logic                WE3,
    output logic                READY
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ZERO_A   = AW'(ZERO_ADDR);

    rf_state_t             state_reg;
    logic [AW-1:0]         clr_idx_reg;
    logic [XLEN-1:0]       regs [DEPTH];
    logic [DEPTH*XLEN-1:0] mem_flat;
    logic                  run;
    logic                  wr_en;

    assign run   = (state_reg == RF_RUN);
    assign READY = run;
    assign wr_en = run && WE3 && !((ZERO_REG != 0) && (A3 == ZERO_A));

    // Clear engine. The counter wraps back to 0 on the final clear edge,
    // so a later reset finds it consistent either way.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= RF_CLEAR;
            clr_idx_reg <= '0;
        end else if (state_reg == RF_CLEAR) begin
            clr_idx_reg <= clr_idx_reg + AW'(1);
            if (clr_idx_reg == LAST_IDX) begin
                state_reg <= RF_RUN;
            end
        end
    end

    // Storage has no reset of its own; the clear engine owns it until RUN.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (!run) begin
                regs[clr_idx_reg] <= '0;
            end else if (wr_en) begin
                regs[A3] <= WD3;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign mem_flat[gi*XLEN +: XLEN] = regs[gi];
        end

        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            regfile_read_port #(
                .XLEN     (XLEN),
                .DEPTH    (DEPTH),
                .ZERO_REG (ZERO_REG)
            ) u_port (
                .run      (run),
                .ra       (RA[gi*AW +: AW]),
                .mem_flat (mem_flat),
`ifdef REGFILE_BYPASS_EN
                .we       (WE3),
                .wa       (A3),
                .wd       (WD3),
`endif
                .rd       (RD[gi*XLEN +: XLEN])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

    logic        clk = 1'b0;
    int          checks = 0;
    int          failures = 0;

    // Instance A: XLEN=32, DEPTH=32, NRD=3, ZERO_REG=1
    logic        rst = 1'b1;
    logic [14:0] ra = '0;
    logic [95:0] rd;
    logic [4:0]  a3 = '0;
    logic [31:0] wd3 = '0;
    logic        we3 = 1'b0;
    logic        ready;

    // Instance B: XLEN=64, DEPTH=16, NRD=2, ZERO_REG=0
    logic         rst_b = 1'b1;
    logic [7:0]   ra_b = '0;
    logic [127:0] rd_b;
    logic [3:0]   a3_b = '0;
    logic [63:0]  wd3_b = '0;
    logic         we3_b = 1'b0;
    logic         ready_b;

    always #5 clk = ~clk;

    regfile_multiport #(.XLEN(32), .DEPTH(32), .NRD(3), .ZERO_REG(1)) dut (
        .CLK(clk), .RST(rst), .RA(ra), .RD(rd),
        .A3(a3), .WD3(wd3), .WE3(we3), .READY(ready)
    );

    regfile_multiport #(.XLEN(64), .DEPTH(16), .NRD(2), .ZERO_REG(0)) dut_b (
        .CLK(clk), .RST(rst_b), .RA(ra_b), .RD(rd_b),
        .A3(a3_b), .WD3(wd3_b), .WE3(we3_b), .READY(ready_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2);
        ra = {p2, p1, p0};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", ready);
        end
        rst = 1'b0;
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'h0000DEAD;
        set_ra(5'd5, 5'd31, 5'd0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            checks++;
            if (ready !== (k == 32)) begin
                failures++;
                $display("FAIL clear_ready cycle=%0d got=%b exp=%b", k, ready, (k == 32));
            end
            if (k == 16) begin
                checks++;
                if (rd !== 96'h0) begin
                    failures++;
                    $display("FAIL clear_rd_zero got=%h exp=0", rd);
                end
            end
        end
        we3 = 1'b0;
        set_ra(5'd5, 5'd31, 5'd0);
        checks++;
        if (rd[31:0] !== 32'h0 || rd[63:32] !== 32'h0) begin
            failures++;
            $display("FAIL clear_drop_write got=%h_%h exp=0_0", rd[63:32], rd[31:0]);
        end
        $display("test_reset done ready=%b", ready);
    endtask

    task automatic test_basic();
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h12345678;
        tick();
        we3 = 1'b0;
        set_ra(5'd7, 5'd7, 5'd0);
        checks++;
        if (rd !== {32'h0, 32'h12345678, 32'h12345678}) begin
            failures++;
            $display("FAIL basic_rw got=%h exp=%h", rd, {32'h0, 32'h12345678, 32'h12345678});
        end
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF;
        set_ra(5'd0, 5'd7, 5'd0);
        checks++;
        if (rd[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL zero_same_cycle got=%h exp=0", rd[31:0]);
        end
        tick();
        we3 = 1'b0;
        set_ra(5'd0, 5'd0, 5'd0);
        checks++;
        if (rd !== 96'h0) begin
            failures++;
            $display("FAIL zero_reg got=%h exp=0", rd);
        end
        $display("test_basic done rd0=%h", rd[31:0]);
    endtask

    task automatic test_rdw();
        logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h00005555;
`else
        exp_same = 32'hAAAA0000;
`endif
        we3 = 1'b1; a3 = 5'd9; wd3 = 32'hAAAA0000;
        tick();
        wd3 = 32'h00005555;
        set_ra(5'd9, 5'd7, 5'd9);
        checks++;
        if (rd[31:0] !== exp_same || rd[95:64] !== exp_same) begin
            failures++;
            $display("FAIL rdw_same got=%h/%h exp=%h", rd[31:0], rd[95:64], exp_same);
        end
        checks++;
        if (rd[63:32] !== 32'h12345678) begin
            failures++;
            $display("FAIL rdw_other_port got=%h exp=12345678", rd[63:32]);
        end
        tick();
        we3 = 1'b0;
        #1;
        checks++;
        if (rd[31:0] !== 32'h00005555) begin
            failures++;
            $display("FAIL rdw_next got=%h exp=00005555", rd[31:0]);
        end
        $display("test_rdw done same=%h", exp_same);
    endtask

    task automatic test_back_to_back();
        we3 = 1'b1;
        a3 = 5'd1; wd3 = 32'h11; tick();
        a3 = 5'd2; wd3 = 32'h22; tick();
        a3 = 5'd3; wd3 = 32'h33; tick();
        we3 = 1'b0;
        set_ra(5'd1, 5'd2, 5'd3);
        checks++;
        if (rd !== {32'h33, 32'h22, 32'h11}) begin
            failures++;
            $display("FAIL back_to_back got=%h exp=%h", rd, {32'h33, 32'h22, 32'h11});
        end
        $display("test_back_to_back done rd=%h", rd);
    endtask

    task automatic test_midrun_reset();
        we3 = 1'b1;
        for (int r = 1; r < 32; r++) begin
            a3 = 5'(r); wd3 = 32'(r);
            tick();
        end
        we3 = 1'b0;
        set_ra(5'd31, 5'd17, 5'd1);
        checks++;
        if (rd !== {32'd1, 32'd17, 32'd31}) begin
            failures++;
            $display("FAIL fill got=%h exp=%h", rd, {32'd1, 32'd17, 32'd31});
        end
        rst = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL midrun_ready_drop got=%b exp=0", ready);
        end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL midrun_ready_rise got=%b exp=1", ready);
        end
        for (int r = 0; r < 32; r += 3) begin
            set_ra(5'(r), 5'((r + 1) % 32), 5'((r + 2) % 32));
            checks++;
            if (rd !== 96'h0) begin
                failures++;
                $display("FAIL midrun_clear base=%0d got=%h exp=0", r, rd);
            end
        end
        $display("test_midrun_reset done ready=%b", ready);
    endtask

    task automatic test_param();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (ready_b !== (k == 16)) begin
                failures++;
                $display("FAIL param_ready cycle=%0d got=%b exp=%b", k, ready_b, (k == 16));
            end
        end
        we3_b = 1'b1; a3_b = 4'd0; wd3_b = 64'h0123456789ABCDEF;
        tick();
        we3_b = 1'b0;
        ra_b = {4'd15, 4'd0};
        #1;
        checks++;
        if (rd_b !== {64'h0, 64'h0123456789ABCDEF}) begin
            failures++;
            $display("FAIL param_reg0 got=%h exp=%h", rd_b, {64'h0, 64'h0123456789ABCDEF});
        end
        $display("test_param done rd0=%h", rd_b[63:0]);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rdw();
        test_back_to_back();
        test_midrun_reset();
        test_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
